// File: rtl/cdr_link_controller.sv
// cdr_link_controller
//   Receive-side link acquisition and supervision behind the clock/data
//   recovery stage. Hunts the recovered bit stream for the framing sync word,
//   confirms lock over several frames, delivers payload bytes while locked,
//   and requests a timed recovery reset on sync loss or loss of activity.
//
// Ports
//   clk_x8     : oversampling clock (only clock)
//   rst        : asynchronous active-high reset
//   bit_in     : recovered data bit
//   bit_valid  : single-cycle qualifier for bit_in (back-to-back allowed)
//   byte_out   : payload byte, MSB received first; holds between strobes
//   byte_valid : single-cycle strobe for byte_out
//   locked     : high while in LOCKED
//   sync_lost  : single-cycle pulse when lock is lost through sync misses
//   cdr_rst    : reset request to the recovery stage, rst_len cycles wide
//   link_state : HUNT=0, VERIFY=1, LOCKED=2, CDR_RESET=3
module cdr_link_controller #(
  parameter logic [7:0]  sync_word    = 8'hD2,
  parameter int unsigned frame_len    = 16,
  parameter int unsigned lock_count   = 4,
  parameter int unsigned miss_limit   = 3,
  parameter int unsigned idle_timeout = 1024,
  parameter int unsigned rst_len      = 4
) (
  input  logic       clk_x8,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       locked,
  output logic       sync_lost,
  output logic       cdr_rst,
  output logic [1:0] link_state
);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    VERIFY    = 2'd1,
    LOCKED    = 2'd2,
    CDR_RESET = 2'd3
  } state_t;

  localparam int unsigned BYTE_W = (frame_len > 1)    ? $clog2(frame_len)    : 1;
  localparam int unsigned GOOD_W = $clog2(lock_count + 1);
  localparam int unsigned MISS_W = $clog2(miss_limit + 1);
  localparam int unsigned IDLE_W = (idle_timeout > 1) ? $clog2(idle_timeout) : 1;
  localparam int unsigned RST_W  = (rst_len > 1)      ? $clog2(rst_len)      : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(frame_len - 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(lock_count);
  localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(miss_limit);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(idle_timeout - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(rst_len - 1);

  state_t            state_q;
  logic [7:0]        sr_q;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-1:0] byte_cnt_q;
  logic [GOOD_W-1:0] good_q;
  logic [MISS_W-1:0] miss_q;
  logic [IDLE_W-1:0] idle_q;
  logic [RST_W-1:0]  rst_cnt_q;
  logic [7:0]        byte_out_q;
  logic              byte_valid_q;
  logic              locked_q;
  logic              sync_lost_q;
  logic              cdr_rst_q;

  logic [7:0] new_byte;
  logic       sync_hit;
  logic       boundary;
  logic       sync_slot;
  logic       idle_expire;
  logic       miss_expire;
  logic       enter_reset;

  always_comb begin
    new_byte    = {sr_q[6:0], bit_in};
    sync_hit    = (new_byte == sync_word);
    boundary    = bit_valid && (bit_cnt_q == 3'd7);
    sync_slot   = boundary && (byte_cnt_q == '0);
    // bit_valid wins over the watchdog, so expiry needs an idle cycle
    idle_expire = (state_q != CDR_RESET) && !bit_valid && (idle_q == IDLE_LAST);
    miss_expire = (state_q == LOCKED) && sync_slot && !sync_hit &&
                  ((miss_q + MISS_W'(1)) == MISS_TGT);
    enter_reset = idle_expire || miss_expire;
  end

  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      idle_q       <= '0;
      rst_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_lost_q  <= 1'b0;
      cdr_rst_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      if (enter_reset) begin
        state_q     <= CDR_RESET;
        cdr_rst_q   <= 1'b1;
        locked_q    <= 1'b0;
        sync_lost_q <= miss_expire;
        sr_q        <= '0;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        good_q      <= '0;
        miss_q      <= '0;
        idle_q      <= '0;
        rst_cnt_q   <= '0;
      end else if (state_q == CDR_RESET) begin
        // cdr_rst falls together with the return to HUNT
        if (rst_cnt_q == RST_LAST) begin
          state_q   <= HUNT;
          cdr_rst_q <= 1'b0;
          rst_cnt_q <= '0;
        end else begin
          rst_cnt_q <= rst_cnt_q + RST_W'(1);
        end
      end else if (!bit_valid) begin
        idle_q <= idle_q + IDLE_W'(1);
      end else begin
        idle_q    <= '0;
        sr_q      <= new_byte;
        // 3-bit counter wraps 7 -> 0 exactly on a byte boundary
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (boundary) begin
          byte_cnt_q <= (byte_cnt_q == BYTE_LAST) ? '0 : byte_cnt_q + BYTE_W'(1);
        end
        case (state_q)
          HUNT: begin
            if (sync_hit) begin
              // the matched byte is slot 0, so the next byte is slot 1
              bit_cnt_q  <= '0;
              byte_cnt_q <= BYTE_W'(1);
              good_q     <= GOOD_W'(1);
              if (lock_count == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end else begin
                state_q <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (sync_slot) begin
              if (sync_hit) begin
                good_q <= good_q + GOOD_W'(1);
                if ((good_q + GOOD_W'(1)) == GOOD_TGT) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  miss_q   <= '0;
                end
              end else begin
                state_q <= HUNT;
                good_q  <= '0;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (byte_cnt_q != '0) begin
                byte_out_q   <= new_byte;
                byte_valid_q <= 1'b1;
              end else if (sync_hit) begin
                miss_q <= '0;
              end else begin
                miss_q <= miss_q + MISS_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign locked     = locked_q;
  assign sync_lost  = sync_lost_q;
  assign cdr_rst    = cdr_rst_q;
  assign link_state = state_q;

endmodule

// File: tb/tb_cdr_link_controller.sv
module tb_cdr_link_controller;

  localparam logic [7:0] SYNC = 8'hD2;
  localparam int FL = 16;
  localparam int LC = 4;
  localparam int ML = 3;
  localparam int IT = 1024;
  localparam int RL = 4;

  logic       clk_x8    = 1'b0;
  logic       rst       = 1'b1;
  logic       bit_in    = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       locked;
  logic       sync_lost;
  logic       cdr_rst;
  logic [1:0] link_state;

  cdr_link_controller #(
    .sync_word   (SYNC),
    .frame_len   (FL),
    .lock_count  (LC),
    .miss_limit  (ML),
    .idle_timeout(IT),
    .rst_len     (RL)
  ) dut (
    .clk_x8    (clk_x8),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .locked    (locked),
    .sync_lost (sync_lost),
    .cdr_rst   (cdr_rst),
    .link_state(link_state)
  );

  always #5 clk_x8 = ~clk_x8;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos counts bits since the sync word was found; every 8th bit completes
  // a byte whose frame slot is (m_pos/8) mod FL.
  int         m_state = 0;
  int         m_pos = 0, m_good = 0, m_miss = 0, m_idle = 0, m_rleft = 0;
  logic [7:0] m_win = '0, m_nb = '0, e_byte = '0;
  logic       e_bv = 0, e_locked = 0, e_lost = 0, e_cdr = 0;

  task automatic m_enter_reset(input logic lost);
    m_state  = 3;
    m_rleft  = RL;
    e_cdr    = 1'b1;
    e_locked = 1'b0;
    e_lost   = lost;
    m_win    = '0;
    m_pos    = 0;
    m_good   = 0;
    m_miss   = 0;
    m_idle   = 0;
  endtask

  initial forever begin
    @(posedge clk_x8 or posedge rst);
    if (rst) begin
      m_state = 0; m_win = '0; m_pos = 0; m_good = 0; m_miss = 0; m_idle = 0; m_rleft = 0;
      e_byte = '0; e_bv = 0; e_locked = 0; e_lost = 0; e_cdr = 0;
    end else begin
      e_bv   = 1'b0;
      e_lost = 1'b0;
      if (m_state == 3) begin
        m_rleft--;
        if (m_rleft == 0) begin
          m_state = 0;
          e_cdr   = 1'b0;
        end
      end else if (!bit_valid) begin
        m_idle++;
        if (m_idle == IT) m_enter_reset(1'b0);
      end else begin
        m_idle = 0;
        m_nb   = {m_win[6:0], bit_in};
        m_win  = m_nb;
        if (m_state == 0) begin
          if (m_nb == SYNC) begin
            m_pos  = 0;
            m_good = 1;
            if (m_good >= LC) begin
              m_state = 2; e_locked = 1'b1; m_miss = 0;
            end else begin
              m_state = 1;
            end
          end
        end else begin
          m_pos++;
          if (m_pos % 8 == 0) begin
            if ((m_pos / 8) % FL == 0) begin
              if (m_state == 1) begin
                if (m_nb == SYNC) begin
                  m_good++;
                  if (m_good == LC) begin
                    m_state = 2; e_locked = 1'b1; m_miss = 0;
                  end
                end else begin
                  m_state = 0;
                  m_good  = 0;
                end
              end else begin
                if (m_nb == SYNC) m_miss = 0;
                else begin
                  m_miss++;
                  if (m_miss == ML) m_enter_reset(1'b1);
                end
              end
            end else if (m_state == 2) begin
              e_byte = m_nb;
              e_bv   = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_x8);
    check("cycle {state,locked,lost,cdr,bv,byte}",
          {link_state, locked, sync_lost, cdr_rst, byte_valid, byte_out},
          {m_state[1:0], e_locked, e_lost, e_cdr, e_bv, e_byte});
  end

  // ---------------- event monitor ----------------
  int         cyc_n = 0, lost_n = 0, cdr_n = 0, lock_hi_n = 0, early_n = 0, rise_cyc = -1;
  logic       locked_prev = 1'b0;
  logic [7:0] sb_val[$];
  int         sb_cyc[$];

  initial forever begin
    @(negedge clk_x8);
    cyc_n++;
    if (byte_valid === 1'b1) begin
      sb_val.push_back(byte_out);
      sb_cyc.push_back(cyc_n);
      if (locked !== 1'b1) early_n++;
    end
    if (sync_lost === 1'b1) lost_n++;
    if (cdr_rst === 1'b1) cdr_n++;
    if (locked === 1'b1) begin
      lock_hi_n++;
      if (locked_prev !== 1'b1 && rise_cyc < 0) rise_cyc = cyc_n;
    end
    locked_prev = locked;
  end

  task automatic clear_mon();
    lost_n = 0; cdr_n = 0; lock_hi_n = 0; early_n = 0; rise_cyc = -1;
    sb_val.delete();
    sb_cyc.delete();
  endtask

  // ---------------- stimulus ----------------
  logic dense = 1'b0;
  int   d2_cyc = 0;

  task automatic tick(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    @(posedge clk_x8);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    if (!dense) idle(int'($urandom_range(0, 3)));
    tick(1'b1, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] s);
    send_byte(s);
    for (int p = 0; p < FL - 1; p++) send_byte(8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  // Random preamble, then 4 frames of sync + payload 0x00..0x0E.
  // Starts from a cleared shift register; preamble is rerolled until it
  // contains no premature sync match (including overlap into the first sync).
  task automatic acquire(input logic dn, input string tag);
    int         seq[44];
    logic       ok;
    logic [7:0] w;
    logic [7:0] s;
    s = SYNC;
    dense = dn;
    do begin
      for (int i = 0; i < 37; i++) seq[i] = int'($urandom_range(0, 1));
      for (int i = 0; i < 7; i++) seq[37 + i] = int'(s[7 - i]);
      ok = 1'b1;
      w  = '0;
      for (int i = 0; i < 44; i++) begin
        w = {w[6:0], seq[i][0]};
        if (w == s) ok = 1'b0;
      end
    end while (!ok);
    clear_mon();
    for (int i = 0; i < 37; i++) send_bit(seq[i][0]);
    for (int f = 0; f < 4; f++) begin
      send_byte(SYNC);
      d2_cyc = cyc_n;
      for (int p = 0; p < FL - 1; p++) send_byte(8'(p));
    end
    idle(3);
    check({tag, " lock_rise_cycle"}, rise_cyc, d2_cyc + 1);
    check({tag, " strobe_count"}, sb_val.size(), 15);
    check({tag, " strobes_before_lock"}, early_n, 0);
    for (int i = 0; i < sb_val.size() && i < 15; i++)
      check({tag, " strobe_value"}, sb_val[i], i);
    if (dn) begin
      for (int i = 1; i < sb_cyc.size(); i++)
        check({tag, " strobe_spacing"}, sb_cyc[i] - sb_cyc[i-1], 8);
    end
  endtask

  initial begin
    // power-on reset
    repeat (3) @(posedge clk_x8);
    #1;
    check("reset_outputs", {byte_out, byte_valid, locked, sync_lost, cdr_rst, link_state}, 0);
    rst = 1'b0;
    idle(2);

    // sparse acquisition
    acquire(1'b0, "acq_sparse");

    // miss tolerance: bad, bad, good, bad, bad keeps lock
    clear_mon();
    dense = 1'b0;
    send_frame(8'h5A);
    send_frame(8'h00);
    send_frame(SYNC);
    send_frame(8'hD3);
    send_frame(8'h52);
    idle(2);
    check("miss_still_locked", locked, 1);
    check("miss_no_lost_yet", lost_n, 0);
    check("miss_no_cdr_yet", cdr_n, 0);
    // third consecutive bad slot
    clear_mon();
    send_byte(8'hF0);
    idle(RL + 4);
    check("miss_lost_pulses", lost_n, 1);
    check("miss_cdr_cycles", cdr_n, RL);
    check("miss_locked_low", locked, 0);
    check("miss_state_hunt", link_state, 0);

    // verify failure: two good frames then D3 in the sync slot
    clear_mon();
    send_frame(SYNC);
    send_frame(SYNC);
    check("vf_in_verify", link_state, 1);
    send_byte(8'hD3);
    idle(2);
    check("vf_state_hunt", link_state, 0);
    check("vf_locked_never", lock_hi_n, 0);
    check("vf_cdr_never", cdr_n, 0);
    check("vf_lost_never", lost_n, 0);

    // back-to-back acquisition
    do_reset();
    acquire(1'b1, "acq_dense");

    // watchdog expiry: acquire already left 3 idle cycles
    clear_mon();
    idle(IT - 4);
    check("wd_1023_idle_no_cdr", cdr_n, 0);
    check("wd_1023_idle_locked", locked, 1);
    idle(1);
    idle(RL + 4);
    check("wd_cdr_cycles", cdr_n, RL);
    check("wd_no_sync_lost", lost_n, 0);
    check("wd_state_hunt", link_state, 0);
    check("wd_locked_low", locked, 0);

    // bit_valid in the last idle cycle rescues the link
    do_reset();
    acquire(1'b1, "acq_dense2");
    clear_mon();
    idle(IT - 4);
    tick(1'b1, 1'b1);
    idle(10);
    check("wd_rescue_no_cdr", cdr_n, 0);
    check("wd_rescue_locked", locked, 1);

    // asynchronous reset mid-LOCKED
    check("ar_locked_before", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_outputs_zero", {byte_out, byte_valid, locked, sync_lost, cdr_rst, link_state}, 0);
    @(posedge clk_x8);
    #1;
    rst = 1'b0;
    idle(1);
    acquire(1'b0, "acq_after_reset");

    // randomized frames with occasional corrupted sync slots
    dense = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0) send_frame(8'($urandom));
      else send_frame(SYNC);
    end
    dense = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(SYNC);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdr_link_controller.md
# cdr_link_controller

Link acquisition and supervision controller that sits directly behind the clock/data recovery stage on the receive side of the fibre link. It consumes the recovered bit stream (`bit_in` qualified by `bit_valid`), hunts for a framing sync word, confirms lock over several frames, and then delivers payload bytes. It also monitors loss of sync and loss of activity, and issues a timed reset pulse to the recovery stage so that it re-acquires.

## Interface

Parameters:
- `sync_word`, 8'hD2, framing byte that occupies slot 0 of every frame.
- `frame_len`, 16, number of bytes per frame including the sync byte. Minimum 2.
- `lock_count`, 4, number of consecutive sync matches needed to declare lock. The hunt match counts as the first.
- `miss_limit`, 3, number of consecutive sync-slot mismatches while locked that declares loss.
- `idle_timeout`, 1024, number of consecutive `clk_x8` cycles without `bit_valid` that triggers a recovery reset.
- `rst_len`, 4, width of the `cdr_rst` pulse in cycles.

Ports:
- `clk_x8`, in, 1, oversampling clock. This is the only clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `bit_in`, in, 1, recovered data bit.
- `bit_valid`, in, 1, single-cycle qualifier for `bit_in`. Back-to-back assertion must be supported.
- `byte_out`, out, 8, payload byte. Bits arrive MSB first.
- `byte_valid`, out, 1, single-cycle strobe for `byte_out`.
- `locked`, out, 1, high while in the LOCKED state.
- `sync_lost`, out, 1, single-cycle pulse when lock is lost through sync misses.
- `cdr_rst`, out, 1, reset request to the recovery stage. Active high.
- `link_state`, out, 2, current state. HUNT=0, VERIFY=1, LOCKED=2, CDR_RESET=3.

## Operation

Datapath:
- Shift register `sr[7:0]`. On each `bit_valid`, `sr <= {sr[6:0], bit_in}`.
- The "new byte" is `{sr[6:0], bit_in}`.
- Bit counter 0..7 and byte counter 0..`frame_len`-1. Both advance only on `bit_valid`.
- A byte boundary occurs on a `bit_valid` when the bit counter is 7. At that point the bit counter wraps to 0 and the byte counter advances modulo `frame_len`.

HUNT:
- Every `bit_valid` compares the new byte with `sync_word`. Matching is bitwise and overlapping.
- On a match: go to VERIFY, set bit counter 0, byte counter 1, good count 1.
- When `lock_count`=1, a match goes to LOCKED directly instead.

VERIFY:
- At a boundary with byte counter 0 (the sync slot):
  - Match: increment good count. When good count reaches `lock_count`, go to LOCKED and clear the miss count.
  - Mismatch: go to HUNT. Do not pulse `cdr_rst`.
- Payload bytes are discarded.

LOCKED:
- At a payload boundary (byte counter ≠ 0): `byte_out` = new byte, and `byte_valid` pulses.
- At a sync-slot boundary:
  - Match: miss count = 0.
  - Mismatch: increment miss count. On reaching `miss_limit`, pulse `sync_lost` and go to CDR_RESET.
- Payload framing continues through missed syncs. The slot is never re-aligned while locked.

CDR_RESET:
- Hold `cdr_rst` high for exactly `rst_len` cycles, then go to HUNT.
- `bit_valid` is ignored in this state.
- On entry, clear the shift register, all counters, and the idle counter.

Idle watchdog (applies in HUNT, VERIFY and LOCKED):
- The idle counter clears on `bit_valid` and increments on every other cycle.
- If the counter equals `idle_timeout`-1 and `bit_valid` is low, go to CDR_RESET.
- If `bit_valid` arrives in that same cycle, `bit_valid` wins: the bit is processed and the counter clears.
- A watchdog expiry from LOCKED does not pulse `sync_lost`.

Counter widths: each counter is `$clog2` of its maximum value plus 1. No counter may wrap unintentionally.

## Timing

- All outputs are registered.
- Reset values: `byte_out`=0, `byte_valid`=0, `locked`=0, `sync_lost`=0, `cdr_rst`=0, `link_state`=HUNT. All internal state is cleared.
- An asserted `rst` takes effect immediately, in any state, including mid-`cdr_rst` pulse.
- `byte_valid`, `byte_out`, `sync_lost`, `locked` and state changes become visible in the cycle after the `bit_valid` that causes them.
- `cdr_rst` rises in the cycle after the triggering event and stays high for `rst_len` cycles. `link_state`=HUNT in the cycle after `cdr_rst` falls.
- `byte_out` holds its last value between strobes.

## Test plan

- **Reset:** assert `rst` mid-LOCKED, asynchronously to `clk_x8` → all outputs 0 and `link_state`=0 before the next edge; hunting resumes after release.
- **Acquisition:** 37 random bits, then 4 frames of D2 followed by payload 0x00–0x0E → `locked` rises 1 cycle after the last bit of the 4th D2; only the 4th frame's 15 bytes are strobed, values 0x00..0x0E; no strobes before lock.
- **Verify failure:** 2 good frames, then the third sync byte is D3 → `link_state` returns to 0 after that byte; `locked`, `cdr_rst` and `sync_lost` never assert.
- **Miss tolerance:** locked; sync slots bad, bad, good, bad, bad → stays locked. Then a third consecutive bad slot → `sync_lost` pulses once, `locked` falls, `cdr_rst` is high for exactly 4 cycles, then HUNT.
- **Watchdog:** locked; `bit_valid` withheld for 1024 cycles → `cdr_rst` for 4 cycles and `sync_lost` stays 0. Repeat with `bit_valid` in cycle 1023 → no reset.
- **Back-to-back:** `bit_valid` high continuously through acquisition → identical results to the sparse stream; byte strobes spaced exactly 8 cycles apart.
